load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the instruction decoder.
- Consumes the decoder's ls/mem_read/mem_write/funct3 strobes, the ALU effective address and the rs2 data, and runs one data-memory transaction per request.
- Returns load_ready to the decoder, which drops its ls strobe on that pulse.
- Produces sign- or zero-extended load data for the register-file write-back mux.

Parameters:
- ADDR_W, 32, data-memory byte-address width.
- ACK_TIMEOUT, 255, cycles to wait for dmem_ack_i before aborting; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- ls_i  in  1  access request from decoder
- mem_read_i  in  1  request is a load
- mem_write_i  in  1  request is a store
- funct3_i  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- addr_i  in  ADDR_W  effective byte address from ALU
- wdata_i  in  32  store data (rs2)
- load_ready_o  out  1  one-cycle completion pulse, for loads and stores
- rdata_o  out  32  extended load result, valid while load_ready_o=1
- err_o  out  1  access aborted (timeout, or misalign when the optional feature is enabled); pulses with load_ready_o
- dmem_req_o  out  1  bus request
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  ADDR_W  word-aligned address, low 2 bits = 0
- dmem_be_o  out  4  byte enables
- dmem_wdata_o  out  32  lane-aligned write data
- dmem_rdata_i  in  32  read word, valid with ack
- dmem_ack_i  in  1  transaction complete

Behaviour:
- All registered outputs reset to 0; FSM resets to IDLE.
- FSM states: IDLE, REQ, DONE.
- IDLE:
  - ls_i & (mem_read_i | mem_write_i) latches addr, wdata, funct3 and we, then goes to REQ next cycle.
  - If both mem_read_i and mem_write_i are set, the access is a write.
  - ls_i with neither read nor write set is ignored.
- REQ:
  - dmem_req_o=1; addr, we, be and wdata are held stable.
  - The timeout counter increments each cycle.
  - dmem_ack_i=1 captures dmem_rdata_i and goes to DONE.
  - When the counter reaches ACK_TIMEOUT (nonzero), go to DONE with err flagged and rdata forced to 0.
  - An ack in the same cycle as the timeout wins; no error is raised.
- DONE:
  - load_ready_o=1, rdata_o valid, err_o as flagged; return to IDLE.
  - ls_i is ignored in DONE.
- Minimum latency, ls_i to load_ready_o: 2 cycles (ack in the first REQ cycle).
- Byte enables, from funct3 and addr[1:0]:
  - B: 1 << addr[1:0]
  - H: 0011 when addr[1]=0, 1100 when addr[1]=1
  - W: 1111
- Store data replication: SB replicates wdata[7:0] to all lanes; SH replicates wdata[15:0] to both halves.
- Load extraction: shift the read word right by 8*addr[1:0], then sign-extend for B/H or zero-extend for BU/HU.
- Stores: rdata_o=0.
- Reset mid-operation aborts any transaction immediately: dmem_req_o drops in the next cycle and no load_ready_o pulse is produced.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - H with addr[0]=1, or W with addr[1:0]!=0, skips REQ.
  - FSM goes IDLE→DONE with err_o=1, rdata_o=0 and no bus activity.
- Undefined:
  - Misaligned addresses are forced aligned: H clears addr[0], W clears addr[1:0].
  - The access proceeds normally and err_o is only raised by timeout.

Decomposition:
- Shared package holds:
  - funct3 size encodings (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU)
  - FSM state encoding
  - decoder opcode constants, so decoder and LSU share them
- One sub-module, lsu_align: purely combinational byte-enable generation, write-lane replication and read extraction, reused by both paths.
- The FSM and timeout counter stay in the top module.

Test Plan:
- LW at 0x100, memory returns 0xDEADBEEF with ack after 3 cycles → dmem_addr 0x100, be 1111, load_ready after 4 cycles, rdata 0xDEADBEEF.
- LB at 0x103, word 0x80FF_0000 → be 1000, rdata 0xFFFFFF80; same with LBU → 0x00000080.
- SH at 0x202, wdata 0x1234ABCD → dmem_addr 0x200, be 1100, dmem_wdata 0xABCDABCD, we=1, load_ready pulse, rdata 0.
- No ack, ACK_TIMEOUT=4 → req held for 4 cycles, then load_ready=1 and err_o=1 with rdata 0; FSM back in IDLE.
- rst_i asserted while in REQ → next cycle dmem_req_o=0, no load_ready pulse; a new LW afterwards completes normally.
- LW at 0x101:
  - with LSU_MISALIGN_TRAP_EN → no dmem_req, load_ready+err one cycle after ls_i.
  - without → dmem_addr 0x100, normal completion.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// ----------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the decoder and the load/store unit:
//   - funct3 access-size encodings (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU)
//   - load/store FSM state encoding
//   - decoder opcode constants for load and store instructions
//   - helpers for access size, misalignment detection and offset forcing
// ----------------------------------------------------------------------------
package load_store_unit_pkg;

    // funct3 encodings: bits [1:0] give the size, bit 2 selects zero-extension.
    localparam logic [2:0] LSU_B  = 3'b000;
    localparam logic [2:0] LSU_H  = 3'b001;
    localparam logic [2:0] LSU_W  = 3'b010;
    localparam logic [2:0] LSU_BU = 3'b100;
    localparam logic [2:0] LSU_HU = 3'b101;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;

    // Major opcodes that the decoder turns into ls/mem_read/mem_write strobes.
    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    // True when the byte offset does not suit the access size.
    // Any size encoding other than byte/half is handled as a word.
    function automatic logic lsu_misaligned(input logic [2:0] funct3,
                                            input logic [1:0] offset);
        case (funct3[1:0])
            SIZE_B:  return 1'b0;
            SIZE_H:  return offset[0];
            default: return offset != 2'b00;
        endcase
    endfunction

    // Rounds the byte offset down to the natural alignment of the access.
    function automatic logic [1:0] lsu_force_align(input logic [2:0] funct3,
                                                   input logic [1:0] offset);
        case (funct3[1:0])
            SIZE_B:  return offset;
            SIZE_H:  return {offset[1], 1'b0};
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
// Purely combinational lane handling shared by the store and load paths.
// Ports:
//   funct3_i  access size/sign
//   offset_i  byte offset within the word (already aligned to the size)
//   wdata_i   store data, right-justified (rs2)
//   rdata_i   word returned by the data memory
//   be_o      byte enables for the access
//   wdata_o   store data replicated onto every lane it may occupy
//   rdata_o   load data shifted down and sign-/zero-extended
// ----------------------------------------------------------------------------
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  offset_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [31:0] shifted;

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would otherwise infer a latch.
        shifted = rdata_i >> {offset_i, 3'b000};
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = shifted;

        case (funct3_i[1:0])
            SIZE_B: begin
                be_o    = 4'b0001 << offset_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = funct3_i[2] ? {24'h0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            SIZE_H: begin
                be_o    = offset_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = funct3_i[2] ? {16'h0, shifted[15:0]}
                                      : {{16{shifted[15]}}, shifted[15:0]};
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ----------------------------------------------------------------------------
// load_store_unit
// Memory-access stage: runs one data-memory transaction per decoder request
// and returns a one-cycle load_ready_o pulse with extended load data.
// Parameters:
//   ADDR_W       data-memory byte-address width
//   ACK_TIMEOUT  REQ cycles to wait for dmem_ack_i before aborting (0 = never)
// Optional build macro:
//   LSU_MISALIGN_TRAP_EN  misaligned H/W accesses finish at once with err_o
//                         and no bus activity; otherwise they are forced
//                         aligned and proceed.
// Ports:
//   clk_i, rst_i                     clock, synchronous active-high reset
//   ls_i, mem_read_i, mem_write_i    request strobes from the decoder
//   funct3_i, addr_i, wdata_i        access size/sign, byte address, store data
//   load_ready_o, rdata_o, err_o     completion pulse, load result, abort flag
//   dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o, dmem_wdata_o   bus request
//   dmem_rdata_i, dmem_ack_i         bus response
// ----------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned ACK_TIMEOUT = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ls_i,
    input  logic              mem_read_i,
    input  logic              mem_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              load_ready_o,
    output logic [31:0]       rdata_o,
    output logic              err_o,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [3:0]        dmem_be_o,
    output logic [31:0]       dmem_wdata_o,
    input  logic [31:0]       dmem_rdata_i,
    input  logic              dmem_ack_i
);

    localparam int unsigned CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;

    lsu_state_e        state_q;
    logic [2:0]        funct3_q;
    logic [1:0]        offset_q;
    logic              we_q;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              timeout;

    logic              load_ready_q, err_q, dmem_req_q, dmem_we_q;
    logic [31:0]       rdata_q, dmem_wdata_q;
    logic [3:0]        dmem_be_q;
    logic [ADDR_W-1:0] dmem_addr_q;

    logic              accept, trap;
    logic [1:0]        offset_in;
    logic [2:0]        align_funct3;
    logic [1:0]        align_offset;
    logic [3:0]        align_be;
    logic [31:0]       align_wdata, align_rdata;

    assign accept    = ls_i & (mem_read_i | mem_write_i);
    assign offset_in = lsu_force_align(funct3_i, addr_i[1:0]);

`ifdef LSU_MISALIGN_TRAP_EN
    assign trap = lsu_misaligned(funct3_i, addr_i[1:0]);
`else
    assign trap = 1'b0;
`endif

    // One aligner serves both paths: while idle it shapes the incoming store,
    // afterwards it extracts the load using the latched size and offset.
    assign align_funct3 = (state_q == IDLE) ? funct3_i  : funct3_q;
    assign align_offset = (state_q == IDLE) ? offset_in : offset_q;

    lsu_align u_align (
        .funct3_i (align_funct3),
        .offset_i (align_offset),
        .wdata_i  (wdata_i),
        .rdata_i  (dmem_rdata_i),
        .be_o     (align_be),
        .wdata_o  (align_wdata),
        .rdata_o  (align_rdata)
    );

    // The counter value seen in REQ cycle k is k-1, so the abort fires in the
    // ACK_TIMEOUT-th REQ cycle unless an ack arrives in that same cycle.
    always_comb begin
        cnt_d   = cnt_q + CNT_W'(1);
        timeout = 1'b0;
        if (ACK_TIMEOUT != 0) begin
            timeout = (cnt_d == CNT_W'(ACK_TIMEOUT));
        end
    end

    always_ff @(posedge clk_i) begin
        // NOTE: state is updated with non-blocking assignments only, so every
        // register samples the values from before this edge.
        if (rst_i) begin
            state_q      <= IDLE;
            funct3_q     <= 3'b000;
            offset_q     <= 2'b00;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            load_ready_q <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_be_q    <= 4'b0000;
            dmem_wdata_q <= 32'h0;
        end else begin
            // Completion outputs are single-cycle pulses.
            load_ready_q <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'h0;

            case (state_q)
                IDLE: begin
                    if (accept) begin
                        funct3_q <= funct3_i;
                        offset_q <= offset_in;
                        we_q     <= mem_write_i;
                        if (trap) begin
                            state_q      <= DONE;
                            load_ready_q <= 1'b1;
                            err_q        <= 1'b1;
                        end else begin
                            state_q      <= REQ;
                            cnt_q        <= '0;
                            dmem_req_q   <= 1'b1;
                            dmem_we_q    <= mem_write_i;
                            dmem_addr_q  <= {addr_i[ADDR_W-1:2], 2'b00};
                            dmem_be_q    <= align_be;
                            dmem_wdata_q <= align_wdata;
                        end
                    end
                end

                REQ: begin
                    cnt_q <= cnt_d;
                    if (dmem_ack_i || timeout) begin
                        state_q      <= DONE;
                        dmem_req_q   <= 1'b0;
                        dmem_we_q    <= 1'b0;
                        load_ready_q <= 1'b1;
                        // Ack has priority over a timeout in the same cycle.
                        err_q        <= ~dmem_ack_i;
                        rdata_q      <= (dmem_ack_i && !we_q) ? align_rdata : 32'h0;
                    end
                end

                DONE: begin
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign load_ready_o = load_ready_q;
    assign rdata_o      = rdata_q;
    assign err_o        = err_q;
    assign dmem_req_o   = dmem_req_q;
    assign dmem_we_o    = dmem_we_q;
    assign dmem_addr_o  = dmem_addr_q;
    assign dmem_be_o    = dmem_be_q;
    assign dmem_wdata_o = dmem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// ----------------------------------------------------------------------------
// tb_load_store_unit
// Directed bench for load_store_unit. A transaction-level model derives the
// bus request and the load result from size/sign arithmetic; a compare
// process checks the DUT against the expected per-cycle view on every
// falling edge, and literal expectations pin the model on key vectors.
// ----------------------------------------------------------------------------
module tb_load_store_unit;

    localparam int unsigned TO = 4;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic        clk, rst_i;
    logic        ls_i, mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        load_ready_o, err_o;
    logic [31:0] rdata_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_rdata_i;
    logic        dmem_ack_i;

    load_store_unit #(.ADDR_W(32), .ACK_TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .ls_i         (ls_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .wdata_i      (wdata_i),
        .load_ready_o (load_ready_o),
        .rdata_o      (rdata_o),
        .err_o        (err_o),
        .dmem_req_o   (dmem_req_o),
        .dmem_we_o    (dmem_we_o),
        .dmem_addr_o  (dmem_addr_o),
        .dmem_be_o    (dmem_be_o),
        .dmem_wdata_o (dmem_wdata_o),
        .dmem_rdata_i (dmem_rdata_i),
        .dmem_ack_i   (dmem_ack_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Expected per-cycle view, driven by the stimulus tasks.
    bit          chk_en = 1'b0;
    bit          exp_req, exp_ready, exp_err, exp_we;
    logic [31:0] exp_addr, exp_wdata, exp_rdata;
    logic [3:0]  exp_be;

    // Values sampled from the DUT during the last access, for literal checks.
    logic [31:0] got_addr, got_wdata, got_rdata;
    logic [3:0]  got_be;
    logic        got_we, got_err, got_ready;

    always @(negedge clk) begin
        if (chk_en) begin
            check("req", dmem_req_o, exp_req);
            check("load_ready", load_ready_o, exp_ready);
            check("err", err_o, exp_ready ? exp_err : 1'b0);
            if (exp_req) begin
                check("dmem_addr", dmem_addr_o, exp_addr);
                check("dmem_be", dmem_be_o, exp_be);
                check("dmem_we", dmem_we_o, exp_we);
                check("dmem_wdata", dmem_wdata_o, exp_wdata);
            end
            if (exp_ready) check("rdata", rdata_o, exp_rdata);
        end
    end

    // Transaction model: size in bytes, natural alignment by rounding down,
    // lanes as a mask shifted by the byte offset, extension by masking.
    function automatic void model(input bit wr, input logic [2:0] f3,
                                  input logic [31:0] a, input logic [31:0] wd,
                                  input logic [31:0] word,
                                  output logic [31:0] m_addr, output logic [3:0] m_be,
                                  output logic [31:0] m_wdata, output logic [31:0] m_rdata,
                                  output bit m_trap);
        int unsigned n, ea, off, be_i;
        logic [31:0] mask, v;
        n       = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        m_trap  = TRAP_EN && ((a % n) != 0);
        ea      = a - (a % n);
        off     = ea % 4;
        m_addr  = a - (a % 4);
        be_i    = ((1 << n) - 1) << off;
        m_be    = be_i[3:0];
        m_wdata = (n == 1) ? wd[7:0] * 32'h01010101 :
                  (n == 2) ? wd[15:0] * 32'h00010001 : wd;
        mask    = (n == 4) ? 32'hFFFFFFFF : (32'h1 << (8 * n)) - 32'h1;
        v       = (word >> (8 * off)) & mask;
        if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~mask;
        m_rdata = wr ? 32'h0 : v;
    endfunction

    // One request; ack_at is the REQ cycle (1-based) carrying the ack, 0 = none.
    task automatic access(input bit rd, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] word, input int ack_at);
        logic [31:0] m_addr, m_wdata, m_rdata;
        logic [3:0]  m_be;
        bit          m_trap, done;
        int          k;
        model(wr, f3, a, wd, word, m_addr, m_be, m_wdata, m_rdata, m_trap);
        @(posedge clk); #1;
        ls_i = 1'b1; mem_read_i = rd; mem_write_i = wr;
        funct3_i = f3; addr_i = a; wdata_i = wd;
        exp_req = 1'b0; exp_ready = 1'b0;
        @(posedge clk); #1;
        exp_err = m_trap;
        done    = m_trap;
        k       = 0;
        got_addr = 32'hX; got_be = 4'hX; got_we = 1'bX; got_wdata = 32'hX;
        while (!done) begin
            k++;
            exp_req = 1'b1; exp_addr = m_addr; exp_be = m_be;
            exp_we = wr; exp_wdata = m_wdata;
            if (k == 1) begin
                got_addr = dmem_addr_o; got_be = dmem_be_o;
                got_we = dmem_we_o; got_wdata = dmem_wdata_o;
            end
            dmem_ack_i   = (k == ack_at);
            dmem_rdata_i = (k == ack_at) ? word : 32'h5A5A5A5A;
            if (k == ack_at) begin
                done = 1'b1; exp_err = 1'b0;
            end else if (k == int'(TO)) begin
                done = 1'b1; exp_err = 1'b1;
            end
            @(posedge clk); #1;
        end
        dmem_ack_i = 1'b0; dmem_rdata_i = 32'h5A5A5A5A;
        exp_req = 1'b0; exp_ready = 1'b1;
        exp_rdata = exp_err ? 32'h0 : m_rdata;
        got_rdata = rdata_o; got_err = err_o; got_ready = load_ready_o;
        ls_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        @(posedge clk); #1;
        exp_ready = 1'b0;
    endtask

    initial begin
        rst_i = 1'b1; ls_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        funct3_i = 3'b000; addr_i = 32'h0; wdata_i = 32'h0;
        dmem_rdata_i = 32'h5A5A5A5A; dmem_ack_i = 1'b0;
        exp_req = 1'b0; exp_ready = 1'b0; exp_err = 1'b0; exp_we = 1'b0;
        exp_addr = 32'h0; exp_be = 4'h0; exp_wdata = 32'h0; exp_rdata = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;

        // Reset state.
        check("rst_ready", load_ready_o, 1'b0);
        check("rst_err", err_o, 1'b0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_req", dmem_req_o, 1'b0);
        check("rst_addr", dmem_addr_o, 32'h0);
        check("rst_be", dmem_be_o, 4'h0);
        chk_en = 1'b1;

        // LW 0x100, ack in third REQ cycle.
        access(1, 0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3);
        check("lw_addr", got_addr, 32'h100);
        check("lw_be", got_be, 4'b1111);
        check("lw_rdata", got_rdata, 32'hDEADBEEF);

        // LB / LBU at 0x103, minimum latency.
        access(1, 0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 1);
        check("lb_be", got_be, 4'b1000);
        check("lb_rdata", got_rdata, 32'hFFFFFF80);
        access(1, 0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 1);
        check("lbu_rdata", got_rdata, 32'h00000080);

        // SH 0x202.
        access(0, 1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2);
        check("sh_addr", got_addr, 32'h200);
        check("sh_be", got_be, 4'b1100);
        check("sh_wdata", got_wdata, 32'hABCDABCD);
        check("sh_we", got_we, 1'b1);
        check("sh_rdata", got_rdata, 32'h0);

        // SB, SW, LH, LHU patterns.
        access(0, 1, 3'b000, 32'h001, 32'h000000A5, 32'h0, 1);
        check("sb_wdata", got_wdata, 32'hA5A5A5A5);
        check("sb_be", got_be, 4'b0010);
        access(0, 1, 3'b010, 32'h304, 32'hCAFEF00D, 32'h0, 1);
        access(1, 0, 3'b001, 32'h002, 32'h0, 32'h80017FFF, 2);
        check("lh_rdata", got_rdata, 32'hFFFF8001);
        access(1, 0, 3'b101, 32'h000, 32'h0, 32'h80017FFF, 1);
        check("lhu_rdata", got_rdata, 32'h00007FFF);

        // Read and write together is a write.
        access(1, 1, 3'b010, 32'h010, 32'h01020304, 32'hFFFFFFFF, 1);
        check("rw_we", got_we, 1'b1);

        // Timeout, then ack in the timeout cycle.
        access(1, 0, 3'b010, 32'h400, 32'h0, 32'h11111111, 0);
        check("to_err", got_err, 1'b1);
        check("to_rdata", got_rdata, 32'h0);
        access(1, 0, 3'b010, 32'h404, 32'h0, 32'h22222222, int'(TO));
        check("to_edge_err", got_err, 1'b0);
        check("to_edge_rdata", got_rdata, 32'h22222222);

        // ls with neither read nor write is ignored.
        @(posedge clk); #1;
        ls_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h500;
        repeat (3) @(posedge clk);
        #1 ls_i = 1'b0;
        repeat (2) @(posedge clk);

        // Reset while in REQ aborts with no completion pulse.
        #1;
        ls_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h600;
        @(posedge clk); #1;
        exp_req = 1'b1; exp_addr = 32'h600; exp_be = 4'b1111; exp_we = 1'b0;
        exp_wdata = dmem_wdata_o;
        @(posedge clk); #1;
        rst_i = 1'b1; ls_i = 1'b0; mem_read_i = 1'b0;
        @(posedge clk); #1;
        rst_i = 1'b0; exp_req = 1'b0; exp_ready = 1'b0;
        repeat (3) @(posedge clk);
        access(1, 0, 3'b010, 32'h700, 32'h0, 32'h0BADF00D, 1);
        check("post_rst_rdata", got_rdata, 32'h0BADF00D);

        // Misaligned word.
        access(1, 0, 3'b010, 32'h101, 32'h0, 32'h76543210, 1);
        if (TRAP_EN) begin
            check("mis_err", got_err, 1'b1);
            check("mis_rdata", got_rdata, 32'h0);
        end else begin
            check("mis_addr", got_addr, 32'h100);
            check("mis_rdata", got_rdata, 32'h76543210);
        end
        // Misaligned half: forced to offset 2 or trapped.
        access(1, 0, 3'b101, 32'h103, 32'h0, 32'hBEEF0000, 1);
        check("mis_h_ready", got_ready, 1'b1);

        repeat (2) @(posedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
